// File: rtl/pixel_buffer.sv
// pixel_buffer
// Pixel store that sits between the SPI byte receiver and the neural-network
// datapath. Up to DEPTH pixels are shifted in from the SPI side. Once the
// chain is full it can be rotated circularly, one entry per request, so the
// network sees every pixel on TAPS parallel taps (slice k = entry[DEPTH-1-k]).
// The block also tracks the load count and the rotation position, and it
// flags end-of-pass and dropped SPI data (overrun).

module pixel_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 72,
    parameter int TAPS   = 2,
    parameter int CNT_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     spi_valid,
    input  logic [DATA_W-1:0]        spi_in,
    input  logic                     net_start,
    input  logic                     net_shift,
    output logic [TAPS*DATA_W-1:0]   pixel_out,
    output logic [CNT_W:0]           load_cnt,
    output logic [CNT_W-1:0]         rot_pos,
    output logic                     buf_full,
    output logic                     busy,
    output logic                     rot_done,
    output logic                     overrun
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_ROTATE  = 2'd3;

    // Load count seen on the cycle that accepts the final pixel.
    localparam logic [CNT_W:0]   LAST_LOAD = (CNT_W+1)'(DEPTH - 1);
    // Full count, used as a hard ceiling for the load counter.
    localparam logic [CNT_W:0]   FULL_LOAD = (CNT_W+1)'(DEPTH);
    // Rotation position at which the next accepted shift closes the pass.
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Storage and control registers
    // ------------------------------------------------------------------
    // chain_r[0] is the input end; chain_r[DEPTH-1] holds the oldest pixel.
    logic [DEPTH-1:0][DATA_W-1:0] chain_r;
    logic [1:0]                   state_r;
    logic [CNT_W:0]               load_cnt_r;
    logic [CNT_W-1:0]             rot_pos_r;
    logic                         buf_full_r;
    logic                         busy_r;
    logic                         rot_done_r;
    logic                         overrun_r;
    logic [TAPS*DATA_W-1:0]       pixel_out_r;

    // ------------------------------------------------------------------
    // Decoded controls for the current cycle
    // ------------------------------------------------------------------
    logic                         load_en_s;   // shift spi_in into the chain
    logic                         drop_s;      // spi_valid arrived while not accepting
    logic                         start_s;     // net_start accepted in FULL
    logic                         rot_en_s;    // net_shift accepted in ROTATE
    logic                         last_s;      // this shift closes the pass
    logic [1:0]                   state_nx_s;
    logic [TAPS*DATA_W-1:0]       tap_s;

    // Decode the request strobes against the current state and pick the next state.
    always_comb begin
        load_en_s  = 1'b0;
        drop_s     = 1'b0;
        start_s    = 1'b0;
        rot_en_s   = 1'b0;
        last_s     = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                load_en_s = spi_valid;
                // DEPTH >= 2, so a single pixel can never fill the chain.
                if (spi_valid) begin
                    state_nx_s = ST_LOADING;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOADING: begin
                load_en_s = spi_valid;
                if (spi_valid && (load_cnt_r == LAST_LOAD)) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_LOADING;
                end
            end
            ST_FULL: begin
                drop_s  = spi_valid;
                // A shift on the same cycle as the start is deliberately ignored.
                start_s = net_start;
                if (net_start) begin
                    state_nx_s = ST_ROTATE;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            ST_ROTATE: begin
                drop_s   = spi_valid;
                rot_en_s = net_shift;
                last_s   = net_shift && (rot_pos_r == LAST_POS);
                if (last_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_ROTATE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Gather the TAPS oldest entries; slice k carries entry[DEPTH-1-k].
    always_comb begin
        tap_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            tap_s[k*DATA_W +: DATA_W] = chain_r[DEPTH-1-k];
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // FSM state register; clear forces the buffer back to empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Pixel chain: shift in new SPI data while loading, rotate oldest-to-input while rotating.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain_r <= '0;
        end else if (clear) begin
            chain_r <= '0;
        end else if (load_en_s) begin
            chain_r <= {chain_r[DEPTH-2:0], spi_in};
        end else if (rot_en_s) begin
            chain_r <= {chain_r[DEPTH-2:0], chain_r[DEPTH-1]};
        end else begin
            chain_r <= chain_r;
        end
    end

    // Count accepted pixels; the counter can never pass DEPTH.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_cnt_r <= '0;
        end else if (clear) begin
            load_cnt_r <= '0;
        end else if (load_en_s && (load_cnt_r != FULL_LOAD)) begin
            load_cnt_r <= load_cnt_r + (CNT_W+1)'(1);
        end else begin
            load_cnt_r <= load_cnt_r;
        end
    end

    // Rotation position: zeroed at pass start and at pass end, otherwise counts accepted shifts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rot_pos_r <= '0;
        end else if (clear) begin
            rot_pos_r <= '0;
        end else if (start_s || last_s) begin
            rot_pos_r <= '0;
        end else if (rot_en_s) begin
            rot_pos_r <= rot_pos_r + CNT_W'(1);
        end else begin
            rot_pos_r <= rot_pos_r;
        end
    end

    // Full flag: set with the final pixel and held through every later pass.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_full_r <= 1'b0;
        end else if (clear) begin
            buf_full_r <= 1'b0;
        end else if (load_en_s && (state_nx_s == ST_FULL)) begin
            buf_full_r <= 1'b1;
        end else begin
            buf_full_r <= buf_full_r;
        end
    end

    // Busy spans the rotation pass, from the accepted start to the closing shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_r <= 1'b0;
        end else if (clear) begin
            busy_r <= 1'b0;
        end else if (start_s) begin
            busy_r <= 1'b1;
        end else if (last_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end

    // End-of-pass pulse, high for exactly the cycle after the closing shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rot_done_r <= 1'b0;
        end else if (clear) begin
            rot_done_r <= 1'b0;
        end else begin
            rot_done_r <= last_s;
        end
    end

    // Sticky overrun: any SPI pixel offered while the chain is not accepting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_r <= 1'b0;
        end else if (clear) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Output taps, sampled from the chain every cycle so they lag a chain update by one edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pixel_out_r <= '0;
        end else if (clear) begin
            pixel_out_r <= '0;
        end else begin
            pixel_out_r <= tap_s;
        end
    end

    // ------------------------------------------------------------------
    // Port drive (all outputs come straight from registers)
    // ------------------------------------------------------------------
    assign pixel_out = pixel_out_r;
    assign load_cnt  = load_cnt_r;
    assign rot_pos   = rot_pos_r;
    assign buf_full  = buf_full_r;
    assign busy      = busy_r;
    assign rot_done  = rot_done_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_pixel_buffer.sv
// Testbench for pixel_buffer: hand-written sequences on the default
// 72-deep instance and a table of directed vectors on a small
// DEPTH=4 / TAPS=4 / DATA_W=16 instance.

module tb_pixel_buffer;

    logic clk;
    logic n_rst;

    // Default instance (DATA_W=8, DEPTH=72, TAPS=2, CNT_W=7)
    logic        b_clear, b_valid, b_start, b_shift;
    logic [7:0]  b_in;
    logic [15:0] b_pix;
    logic [7:0]  b_lc;
    logic [6:0]  b_rp;
    logic        b_full, b_busy, b_done, b_ovr;

    // Small instance (DATA_W=16, DEPTH=4, TAPS=4, CNT_W=2)
    logic        s_clear, s_valid, s_start, s_shift;
    logic [15:0] s_in;
    logic [63:0] s_pix;
    logic [2:0]  s_lc;
    logic [1:0]  s_rp;
    logic        s_full, s_busy, s_done, s_ovr;

    int tests_run = 0;
    int tests_failed = 0;

    pixel_buffer u_big (
        .clk(clk), .n_rst(n_rst), .clear(b_clear), .spi_valid(b_valid),
        .spi_in(b_in), .net_start(b_start), .net_shift(b_shift),
        .pixel_out(b_pix), .load_cnt(b_lc), .rot_pos(b_rp),
        .buf_full(b_full), .busy(b_busy), .rot_done(b_done), .overrun(b_ovr)
    );

    pixel_buffer #(.DATA_W(16), .DEPTH(4), .TAPS(4)) u_small (
        .clk(clk), .n_rst(n_rst), .clear(s_clear), .spi_valid(s_valid),
        .spi_in(s_in), .net_start(s_start), .net_shift(s_shift),
        .pixel_out(s_pix), .load_cnt(s_lc), .rot_pos(s_rp),
        .buf_full(s_full), .busy(s_busy), .rot_done(s_done), .overrun(s_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] din;
        logic        start;
        logic        shift;
        logic        clr;
        logic [63:0] e_pix;
        logic [2:0]  e_lc;
        logic [1:0]  e_rp;
        logic        e_full;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_big_zero(input string nm);
        check({nm, " pix"},  64'(b_pix),  64'd0);
        check({nm, " lc"},   64'(b_lc),   64'd0);
        check({nm, " rp"},   64'(b_rp),   64'd0);
        check({nm, " full"}, 64'(b_full), 64'd0);
        check({nm, " busy"}, 64'(b_busy), 64'd0);
        check({nm, " done"}, 64'(b_done), 64'd0);
        check({nm, " ovr"},  64'(b_ovr),  64'd0);
    endtask

    initial begin
        int done_cnt;
        int gap;

        // Directed table for the small instance. Taps are {slice3,slice2,slice1,slice0}
        // with slice k = entry[3-k], one edge behind the chain.
        //            valid din       st    sh    clr   pix                     lc    rp    full  busy  done  ovr
        vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 64'h1111_0000_0000_0000, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 64'h2222_1111_0000_0000, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 64'h3333_2222_1111_0000, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h1111_4444_3333_2222, 3'd4, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h1111_4444_3333_2222, 3'd4, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h2222_1111_4444_3333, 3'd4, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h3333_2222_1111_4444, 3'd4, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h4444_3333_2222_1111, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0000, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        n_rst   = 1'b0;
        b_clear = 1'b0; b_valid = 1'b0; b_start = 1'b0; b_shift = 1'b0; b_in = 8'd0;
        s_clear = 1'b0; s_valid = 1'b0; s_start = 1'b0; s_shift = 1'b0; s_in = 16'd0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check_big_zero("reset");
        n_rst = 1'b1;
        tick();

        // ---------------- load ramp 1..72 ----------------
        for (int i = 1; i <= 72; i++) begin
            b_valid = 1'b1;
            b_in    = 8'(i);
            tick();
            if (i == 71) check("ramp not full at 71", 64'(b_full), 64'd0);
        end
        b_valid = 1'b0;
        check("ramp lc", 64'(b_lc), 64'd72);
        check("ramp full", 64'(b_full), 64'd1);
        check("ramp busy", 64'(b_busy), 64'd0);
        tick();
        check("ramp tap0", 64'(b_pix[7:0]), 64'd1);
        check("ramp tap1", 64'(b_pix[15:8]), 64'd2);

        // ---------------- net_shift before net_start ----------------
        b_shift = 1'b1;
        tick();
        b_shift = 1'b0;
        check("early shift rp", 64'(b_rp), 64'd0);
        check("early shift busy", 64'(b_busy), 64'd0);
        tick();
        check("early shift taps", 64'(b_pix), 64'h0201);

        // ---------------- overrun ----------------
        b_valid = 1'b1;
        b_in    = 8'hAA;
        tick();
        b_valid = 1'b0;
        check("overrun set", 64'(b_ovr), 64'd1);
        check("overrun lc", 64'(b_lc), 64'd72);
        tick();
        check("overrun taps", 64'(b_pix), 64'h0201);

        // ---------------- full rotation pass with gaps ----------------
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("start busy", 64'(b_busy), 64'd1);
        check("start rp", 64'(b_rp), 64'd0);
        done_cnt = 0;
        for (int j = 1; j <= 72; j++) begin
            b_shift = 1'b1;
            tick();
            b_shift = 1'b0;
            done_cnt += int'(b_done);
            check($sformatf("pass rp j=%0d", j), 64'(b_rp), 64'(j % 72));
            check($sformatf("pass busy j=%0d", j), 64'(b_busy), (j == 72) ? 64'd0 : 64'd1);
            tick();
            check($sformatf("pass done low j=%0d", j), 64'(b_done), 64'd0);
            check($sformatf("pass taps j=%0d", j), 64'(b_pix),
                  64'({8'(((j + 1) % 72) + 1), 8'((j % 72) + 1)}));
            gap = (j % 9 == 4) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g < gap; g++) begin
                tick();
                check($sformatf("gap rp j=%0d", j), 64'(b_rp), 64'(j % 72));
                check($sformatf("gap taps j=%0d", j), 64'(b_pix),
                      64'({8'(((j + 1) % 72) + 1), 8'((j % 72) + 1)}));
            end
        end
        check("pass done count", 64'(done_cnt), 64'd1);
        check("pass overrun kept", 64'(b_ovr), 64'd1);
        check("pass full kept", 64'(b_full), 64'd1);

        // ---------------- clear mid-pass ----------------
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_shift = 1'b1;
        repeat (30) tick();
        check("pre-clear rp", 64'(b_rp), 64'd30);
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        b_shift = 1'b0;
        check_big_zero("clear");
        tick();
        check("clear idle pix", 64'(b_pix), 64'd0);
        for (int i = 1; i <= 72; i++) begin
            b_valid = 1'b1;
            b_in    = 8'(100 + i);
            tick();
        end
        b_valid = 1'b0;
        check("reload lc", 64'(b_lc), 64'd72);
        check("reload full", 64'(b_full), 64'd1);
        check("reload ovr", 64'(b_ovr), 64'd0);
        tick();
        check("reload taps", 64'(b_pix), 64'h6665);

        // ---------------- async reset mid-load ----------------
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            b_valid = 1'b1;
            b_in    = 8'(i);
            tick();
        end
        b_valid = 1'b0;
        check("mid-load lc", 64'(b_lc), 64'd40);
        #1;
        n_rst = 1'b0;
        #1;
        check_big_zero("async reset");
        tick();
        n_rst = 1'b1;
        tick();

        // ---------------- small instance table ----------------
        for (int i = 0; i < 16; i++) begin
            s_valid = vecs[i].valid;
            s_in    = vecs[i].din;
            s_start = vecs[i].start;
            s_shift = vecs[i].shift;
            s_clear = vecs[i].clr;
            tick();
            check($sformatf("v%0d pix", i),  s_pix,          vecs[i].e_pix);
            check($sformatf("v%0d lc", i),   64'(s_lc),      64'(vecs[i].e_lc));
            check($sformatf("v%0d rp", i),   64'(s_rp),      64'(vecs[i].e_rp));
            check($sformatf("v%0d full", i), 64'(s_full),    64'(vecs[i].e_full));
            check($sformatf("v%0d busy", i), 64'(s_busy),    64'(vecs[i].e_busy));
            check($sformatf("v%0d done", i), 64'(s_done),    64'(vecs[i].e_done));
            check($sformatf("v%0d ovr", i),  64'(s_ovr),     64'(vecs[i].e_ovr));
        end
        s_valid = 1'b0; s_start = 1'b0; s_shift = 1'b0; s_clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
